// File: rtl/rc4_msg_checker.sv
// rtl/rc4_msg_checker.sv - plaintext alphabet checker for the RC4 decrypted-message RAM
//
// Scans addresses 0..MSG_LEN-1 of the decrypted-message RAM and reports whether
// every byte is in the legal alphabet ('a'..'z' or space).
// Optional feature macro: RC4_CHK_EARLY_ABORT_EN (stop at the first illegal byte).
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   sig_start  level scan request, held until chk_done is seen
//   ram_addr   RAM read address
//   ram_q      RAM read data, valid RD_LAT cycles after ram_addr
//   chk_done   scan complete, verdict valid while high
//   chk_pass   1 when every scanned byte was legal
//   fail_addr  address of the first illegal byte (0 on pass)
//   fail_cnt   saturating count of illegal bytes

module rc4_msg_checker #(
   parameter int MSG_LEN = 32,
   parameter int ADDR_W  = 5,
   parameter int RD_LAT  = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              sig_start,
   output logic [ADDR_W-1:0] ram_addr,
   input  logic [7:0]        ram_q,
   output logic              chk_done,
   output logic              chk_pass,
   output logic [ADDR_W-1:0] fail_addr,
   output logic [ADDR_W:0]   fail_cnt
);

   localparam int                CNT_W     = 2;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MSG_LEN - 1);
   localparam logic [CNT_W-1:0]  WAIT_LOAD = CNT_W'(RD_LAT - 1);

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT,
      CHECK,
      DONE
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [CNT_W-1:0]  wait_q, wait_d;
   logic              done_q, done_d;
   logic              pass_q, pass_d;
   logic [ADDR_W-1:0] faddr_q, faddr_d;
   logic [ADDR_W:0]   fcnt_q, fcnt_d;
   logic              first_q, first_d;

   logic byte_legal;
   logic abort_now;

   assign byte_legal = ((ram_q >= 8'h61) && (ram_q <= 8'h7A)) || (ram_q == 8'h20);

`ifdef RC4_CHK_EARLY_ABORT_EN
   assign abort_now = ~byte_legal;
`else
   assign abort_now = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         addr_q  <= '0;
         wait_q  <= '0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         faddr_q <= '0;
         fcnt_q  <= '0;
         first_q <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wait_q  <= wait_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
         faddr_q <= faddr_d;
         fcnt_q  <= fcnt_d;
         first_q <= first_d;
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wait_d  = wait_q;
      done_d  = done_q;
      pass_d  = pass_q;
      faddr_d = faddr_q;
      fcnt_d  = fcnt_q;
      first_d = first_q;

      case (state_q)
         IDLE: begin
            if (sig_start) begin
               addr_d  = '0;
               fcnt_d  = '0;
               faddr_d = '0;
               first_d = 1'b0;
               pass_d  = 1'b0;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            wait_d  = WAIT_LOAD;
            state_d = WAIT;
         end
         WAIT: begin
            // Counter starts at RD_LAT-1, so WAIT spans exactly RD_LAT cycles.
            if (wait_q == '0) begin
               state_d = CHECK;
            end else begin
               wait_d = wait_q - 1'b1;
            end
         end
         CHECK: begin
            if (!byte_legal) begin
               if (fcnt_q != '1) begin
                  fcnt_d = fcnt_q + 1'b1;
               end
               if (!first_q) begin
                  faddr_d = addr_q;
                  first_d = 1'b1;
               end
            end
            if ((addr_q == LAST_ADDR) || abort_now) begin
               // Verdict uses the count including the byte checked this cycle.
               pass_d  = (fcnt_d == '0);
               done_d  = 1'b1;
               state_d = DONE;
            end else begin
               addr_d  = addr_q + 1'b1;
               state_d = ISSUE;
            end
         end
         DONE: begin
            if (!sig_start) begin
               done_d  = 1'b0;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign ram_addr  = addr_q;
   assign chk_done  = done_q;
   assign chk_pass  = pass_q;
   assign fail_addr = faddr_q;
   assign fail_cnt  = fcnt_q;

endmodule

// File: tb/tb_rc4_msg_checker.sv
// tb/tb_rc4_msg_checker.sv - self-checking bench for rc4_msg_checker

module tb_rc4_msg_checker;

   localparam int MSG_LEN = 32;
   localparam int ADDR_W  = 5;
   localparam int RD_LAT  = 2;
`ifdef RC4_CHK_EARLY_ABORT_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              sig_start = 1'b0;
   logic [ADDR_W-1:0] ram_addr;
   logic [7:0]        ram_q;
   logic              chk_done;
   logic              chk_pass;
   logic [ADDR_W-1:0] fail_addr;
   logic [ADDR_W:0]   fail_cnt;

   int errors = 0;
   int checks = 0;

   rc4_msg_checker #(.MSG_LEN(MSG_LEN), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .sig_start (sig_start),
      .ram_addr  (ram_addr),
      .ram_q     (ram_q),
      .chk_done  (chk_done),
      .chk_pass  (chk_pass),
      .fail_addr (fail_addr),
      .fail_cnt  (fail_cnt)
   );

   always #5 clk = ~clk;

   // RAM model: read data emerges RD_LAT clocks after the address is presented.
   logic [7:0] mem  [MSG_LEN];
   logic [7:0] pipe [RD_LAT];

   always @(posedge clk) begin
      pipe[0] <= mem[ram_addr];
      for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
   end
   assign ram_q = pipe[RD_LAT-1];

   function automatic bit is_legal(input logic [7:0] b);
      return b inside {8'h20, [8'h61:8'h7A]};
   endfunction

   // Reference verdict and latency derived from the message contents.
   task automatic model(output bit p, output int fa, output int fc, output int lat);
      int first;
      first = -1;
      fc = 0;
      for (int k = 0; k < MSG_LEN; k++) begin
         if (!is_legal(mem[k])) begin
            if (first < 0) first = k;
            fc++;
            if (EARLY) break;
         end
      end
      p   = (fc == 0);
      fa  = (first < 0) ? 0 : first;
      lat = 1 + (((EARLY && first >= 0) ? first + 1 : MSG_LEN) * (RD_LAT + 2));
   endtask

   // Raise sig_start and count clocks until chk_done; optionally drop start at cycle 10.
   task automatic run_scan(input bit drop_early, output int cyc, output bit addr_ok);
      @(negedge clk);
      sig_start = 1'b1;
      cyc = 0;
      addr_ok = 1'b1;
      while (cyc < 2000) begin
         @(posedge clk);
         #1;
         cyc++;
         if (int'(ram_addr) > MSG_LEN - 1) addr_ok = 1'b0;
         if (drop_early && cyc == 10) sig_start = 1'b0;
         if (chk_done) break;
      end
   endtask

   task automatic fill_legal();
      for (int k = 0; k < MSG_LEN; k++) mem[k] = (k % 3 == 0) ? 8'h20 : 8'(8'h61 + $urandom_range(0, 25));
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      sig_start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({ram_addr, chk_done, chk_pass, fail_addr, fail_cnt} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got addr=%0d done=%0b pass=%0b faddr=%0d fcnt=%0d required all 0",
                  ram_addr, chk_done, chk_pass, fail_addr, fail_cnt);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_all_legal();
      string s;
      bit p; int fa, fc, lat, cyc; bit aok;
      s = "attack at dawn";
      for (int k = 0; k < MSG_LEN; k++) mem[k] = (k < s.len()) ? s[k] : 8'h20;
      model(p, fa, fc, lat);
      run_scan(1'b0, cyc, aok);
      checks++;
      if (cyc !== lat || chk_pass !== 1'b1 || int'(fail_addr) !== 0 || int'(fail_cnt) !== 0) begin
         errors++;
         $display("FAIL all_legal: got cyc=%0d pass=%0b faddr=%0d fcnt=%0d required cyc=%0d pass=1 faddr=0 fcnt=0",
                  cyc, chk_pass, fail_addr, fail_cnt, lat);
      end
      @(negedge clk);
      sig_start = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (chk_done !== 1'b0 || chk_pass !== 1'b1) begin
         errors++;
         $display("FAIL done_release: got done=%0b pass=%0b required done=0 pass=1", chk_done, chk_pass);
      end
   endtask

   task automatic test_two_errors();
      bit p; int fa, fc, lat, cyc; bit aok;
      for (int k = 0; k < MSG_LEN; k++) mem[k] = 8'h61;
      mem[5]  = 8'h7B;
      mem[20] = 8'h41;
      model(p, fa, fc, lat);
      run_scan(1'b0, cyc, aok);
      checks++;
      if (cyc !== lat || chk_pass !== 1'b0 || int'(fail_addr) !== 5 || int'(fail_cnt) !== (EARLY ? 1 : 2)) begin
         errors++;
         $display("FAIL two_errors: got cyc=%0d pass=%0b faddr=%0d fcnt=%0d required cyc=%0d pass=0 faddr=5 fcnt=%0d",
                  cyc, chk_pass, fail_addr, fail_cnt, lat, EARLY ? 1 : 2);
      end
      @(negedge clk);
      sig_start = 1'b0;
      @(posedge clk);
   endtask

   task automatic test_boundary();
      bit p; int fa, fc, lat, cyc; bit aok;
      for (int k = 0; k < MSG_LEN; k++) mem[k] = 8'h61;
      mem[0] = 8'h61; mem[1] = 8'h7A; mem[2] = 8'h20; mem[3] = 8'h60; mem[4] = 8'h1F;
      model(p, fa, fc, lat);
      run_scan(1'b0, cyc, aok);
      checks++;
      if (cyc !== lat || chk_pass !== 1'b0 || int'(fail_addr) !== 3 || int'(fail_cnt) !== fc) begin
         errors++;
         $display("FAIL boundary_low: got cyc=%0d pass=%0b faddr=%0d fcnt=%0d required cyc=%0d pass=0 faddr=3 fcnt=%0d",
                  cyc, chk_pass, fail_addr, fail_cnt, lat, fc);
      end
      @(negedge clk);
      sig_start = 1'b0;
      @(posedge clk);
      // 0x21 at the last address, 0x7A / 0x20 elsewhere: only the final byte fails.
      for (int k = 0; k < MSG_LEN; k++) mem[k] = (k % 2 == 0) ? 8'h7A : 8'h20;
      mem[MSG_LEN-1] = 8'h21;
      model(p, fa, fc, lat);
      run_scan(1'b0, cyc, aok);
      checks++;
      if (cyc !== lat || chk_pass !== 1'b0 || int'(fail_addr) !== MSG_LEN - 1 || int'(fail_cnt) !== 1 || !aok) begin
         errors++;
         $display("FAIL boundary_last: got cyc=%0d pass=%0b faddr=%0d fcnt=%0d addr_ok=%0b required cyc=%0d pass=0 faddr=%0d fcnt=1 addr_ok=1",
                  cyc, chk_pass, fail_addr, fail_cnt, aok, lat, MSG_LEN - 1);
      end
      @(negedge clk);
      sig_start = 1'b0;
      @(posedge clk);
   endtask

   task automatic test_random();
      bit p; int fa, fc, lat, cyc; bit aok;
      for (int t = 0; t < 8; t++) begin
         fill_legal();
         if (t != 0) begin
            for (int e = 0; e < int'($urandom_range(1, 6)); e++) mem[$urandom_range(0, MSG_LEN-1)] = 8'($urandom);
         end
         model(p, fa, fc, lat);
         run_scan(1'b0, cyc, aok);
         checks++;
         if (cyc !== lat || chk_pass !== p || int'(fail_addr) !== fa || int'(fail_cnt) !== fc || !aok) begin
            errors++;
            $display("FAIL random_%0d: got cyc=%0d pass=%0b faddr=%0d fcnt=%0d addr_ok=%0b required cyc=%0d pass=%0b faddr=%0d fcnt=%0d addr_ok=1",
                     t, cyc, chk_pass, fail_addr, fail_cnt, aok, lat, p, fa, fc);
         end
         @(negedge clk);
         sig_start = 1'b0;
         @(posedge clk);
      end
   endtask

   task automatic test_mid_reset();
      bit p; int fa, fc, lat, cyc; bit aok;
      for (int k = 0; k < MSG_LEN; k++) mem[k] = 8'h41;
      @(negedge clk);
      sig_start = 1'b1;
      repeat (40) @(posedge clk);
      #1;
      rst_n = 1'b0;
      sig_start = 1'b0;
      #1;
      checks++;
      if ({ram_addr, chk_done, chk_pass, fail_addr, fail_cnt} !== '0) begin
         errors++;
         $display("FAIL mid_reset: got addr=%0d done=%0b pass=%0b faddr=%0d fcnt=%0d required all 0",
                  ram_addr, chk_done, chk_pass, fail_addr, fail_cnt);
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      checks++;
      if (chk_done !== 1'b0 || ram_addr !== '0) begin
         errors++;
         $display("FAIL reset_idle: got done=%0b addr=%0d required done=0 addr=0", chk_done, ram_addr);
      end
      fill_legal();
      model(p, fa, fc, lat);
      run_scan(1'b0, cyc, aok);
      checks++;
      if (cyc !== lat || chk_pass !== 1'b1 || int'(fail_cnt) !== 0) begin
         errors++;
         $display("FAIL post_reset_scan: got cyc=%0d pass=%0b fcnt=%0d required cyc=%0d pass=1 fcnt=0",
                  cyc, chk_pass, fail_cnt, lat);
      end
      @(negedge clk);
      sig_start = 1'b0;
      @(posedge clk);
   endtask

   task automatic test_start_control();
      bit p; int fa, fc, lat, cyc; bit aok; bit stayed;
      fill_legal();
      mem[9] = 8'h7B;
      model(p, fa, fc, lat);
      run_scan(1'b1, cyc, aok);
      checks++;
      if (cyc !== lat || chk_pass !== 1'b0 || int'(fail_addr) !== 9 || int'(fail_cnt) !== 1) begin
         errors++;
         $display("FAIL start_drop: got cyc=%0d pass=%0b faddr=%0d fcnt=%0d required cyc=%0d pass=0 faddr=9 fcnt=1",
                  cyc, chk_pass, fail_addr, fail_cnt, lat);
      end
      @(posedge clk);
      #1;
      checks++;
      if (chk_done !== 1'b0 || int'(fail_addr) !== 9 || int'(fail_cnt) !== 1) begin
         errors++;
         $display("FAIL verdict_hold: got done=%0b faddr=%0d fcnt=%0d required done=0 faddr=9 fcnt=1",
                  chk_done, fail_addr, fail_cnt);
      end
      // Start held high after done must not launch a second scan.
      fill_legal();
      model(p, fa, fc, lat);
      run_scan(1'b0, cyc, aok);
      stayed = 1'b1;
      repeat (3 * MSG_LEN * (RD_LAT + 2)) begin
         @(posedge clk);
         #1;
         if (chk_done !== 1'b1 || int'(ram_addr) !== MSG_LEN - 1) stayed = 1'b0;
      end
      checks++;
      if (cyc !== lat || stayed !== 1'b1) begin
         errors++;
         $display("FAIL start_hold: got cyc=%0d held=%0b required cyc=%0d held=1", cyc, stayed, lat);
      end
      @(negedge clk);
      sig_start = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (chk_done !== 1'b0) begin
         errors++;
         $display("FAIL hold_release: got done=%0b required 0", chk_done);
      end
      mem[7] = 8'h00;
      model(p, fa, fc, lat);
      run_scan(1'b0, cyc, aok);
      checks++;
      if (cyc !== lat || chk_pass !== 1'b0 || int'(fail_addr) !== 7 || int'(fail_cnt) !== 1) begin
         errors++;
         $display("FAIL rescan: got cyc=%0d pass=%0b faddr=%0d fcnt=%0d required cyc=%0d pass=0 faddr=7 fcnt=1",
                  cyc, chk_pass, fail_addr, fail_cnt, lat);
      end
      @(negedge clk);
      sig_start = 1'b0;
      @(posedge clk);
   endtask

   initial begin
      for (int k = 0; k < MSG_LEN; k++) mem[k] = 8'h20;
      test_reset();
      test_all_legal();
      test_two_errors();
      test_boundary();
      test_random();
      test_mid_reset();
      test_start_control();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
